linear_cordic_vectoring_mode: RTL and testbench
===============================================

Name: linear_cordic_vectoring_mode

Overview:
- 16-stage pipelined linear CORDIC in vectoring mode: drives Y toward zero and accumulates Z_O = Z_i + Y_i/X_i.
- Inverse-direction companion to linear_cordic_rotation_mode, which computes Y + X·Z. It provides the divide/ratio path for the same CORDIC processing units.
- Fully pipelined, one sample per clock, no backpressure.

Parameters:
- WIDTH, 16, I/O word width; signed Q1.14 (16384 = 1.0).
- STAGES, 16, iteration count; stage i uses shift i, for i = 0..STAGES-1.
- GUARD, 2, extra LSB and extra MSB bits in the internal Y/Z datapath.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_i  in  1  input sample qualifier.
- X_i  in  16  signed divisor, Q1.14.
- Y_i  in  16  signed dividend, Q1.14.
- Z_i  in  16  signed accumulator seed, Q1.14.
- valid_o  out  1  output qualifier.
- X_O  out  16  X_i passed through, delay-matched.
- Y_O  out  16  residual Y, near 0; saturated.
- Z_O  out  16  Z_i + Y_i/X_i, Q1.14; saturated.
- err_o  out  1  divide-by-zero flag; X_i was 0 for this sample.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge.
- Reset values: every pipeline register is cleared to 0, so valid_o=0, err_o=0, X_O=0, Y_O=0, Z_O=0.
- Latency: a sample accepted at edge k (valid_i=1) appears on the outputs after edge k+16. Throughput is 1 per cycle.
- Valid handling: valid_i travels down a 16-bit shift chain.
  - Data registers advance every cycle regardless of valid.
  - Outputs are meaningful only while valid_o=1.
- Internal format: Y and Z are sign-extended to WIDTH+2·GUARD = 20 bits, Q3.16.
  - Entry: Y and Z are shifted left by GUARD.
  - X is kept at 16 bits and sign-extended to 20 bits, shifted left by GUARD, before being added into Y.
- Stage i direction: d = +1 if sign bit of y ≠ sign bit of x, else d = −1. Zero counts as positive.
- Stage i update:
  - y' = y + d·(x_ext >>> i), arithmetic shift.
  - z' = z − d·(1 << (16−i)).
  - The increment constants are 2^-i in Q3.16 and are never zero for i ≤ 15.
- Output conversion:
  - Z_O = sat16(z >>> GUARD), truncation. Saturate to +32767 / −32768 when the value exceeds the 16-bit range.
  - Y_O uses the same conversion.
- Convergence range: |Y_i/X_i| ≤ 2 − 2^-15. Outside this range Z_O is the saturated or clamped CORDIC value; no error is flagged.
- Accuracy: |Z_O − true| ≤ 2 LSB for in-range inputs with |X_i| ≥ 1024.
- Divide by zero: X_i == 0 sets a sideband bit that travels with the sample and appears as err_o together with valid_o.
  - Z then drifts monotonically: with x=0 and y≥0, d = −1 every stage, so Z_O = sat(Z_i + ~2.0).
  - err_o is only meaningful while valid_o=1.
- Back-to-back samples: no interaction between samples. Each stage holds an independent sample.
- Reset mid-operation: all in-flight samples are discarded.
  - valid_o is 0 from the edge after reset is asserted.
  - The first post-reset sample emerges 16 cycles after it is accepted.
- valid_i=0 with changing X_i/Y_i/Z_i has no effect on valid_o and raises no error.

Decomposition:
- cordic_pkg (shared with the rotation block) holds:
  - Q-format constants: WIDTH, FRAC=14, GUARD.
  - sat16 function.
  - Linear increment function inc(i) = 1 << (FRAC+GUARD−i).
- One sub-module, linear_cordic_vectoring_stage, parameterised by STAGE index. It holds:
  - Registered x, y, z, valid, err.
  - Direction decision and add/subtract.
- The top level holds the input extension, a generate loop of STAGES stages, and the output saturation register.

Test Plan:
- Reset held 3 cycles with random inputs → all outputs 0. Release, X=8192, Y=4096, Z=0, valid_i=1 for 1 cycle → exactly 16 cycles later valid_o=1 for 1 cycle and Z_O=8192±2 (0.25/0.5=0.5); X_O=8192; |Y_O|≤2.
- Sign cases with Z=0:
  - X=−8192, Y=4096 → Z_O=−8192±2.
  - X=16384, Y=−8192 → Z_O=−8192±2.
  - X=−8192, Y=−4096 → Z_O=8192±2.
- Accumulate: X=8192, Y=4096, Z=4096 → Z_O=12288±2. Edge range: X=8192, Y=16000 → Z_O=32000±2.
- Streaming: 20 consecutive valid samples with random in-range X (|X|≥1024), Y, Z=0 → 20 consecutive valid_o pulses in order, each matching the Z + Y/X reference within 2 LSB.
- Error and saturation:
  - X=0, Y=4096, Z=0 → err_o=1 with valid_o; Z_O=32767.
  - X=4096, Y=16384 (ratio 4) → err_o=0, Z_O=32767.
  - X=0, Y=−4096 → Z_O=−32768, err_o=1.
- Reset mid-stream: inject 8 samples, assert reset for 1 cycle at the 5th sample → valid_o stays 0 until the first post-reset sample, which emerges 16 cycles after acceptance with the correct value.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared Q-format constants, bundle types and helpers for the
// linear CORDIC rotation/vectoring pipelines.
package cordic_pkg;

  localparam int WIDTH = 16;
  localparam int FRAC  = 14;
  localparam int GUARD = 2;
  localparam int IW    = WIDTH + 2 * GUARD;

  typedef logic signed [WIDTH-1:0] word_t;
  typedef logic signed [IW-1:0]    ival_t;

  typedef struct packed {
    logic  valid;
    logic  err;
    word_t x;
    ival_t y;
    ival_t z;
  } vec_t;

  localparam ival_t SMAX = ival_t'((1 <<< (WIDTH - 1)) - 1);
  localparam ival_t SMIN = ival_t'(-(1 <<< (WIDTH - 1)));

  // 2^-i expressed in the Q3.16 internal format
  function automatic ival_t inc(input int i);
    return ival_t'(1) <<< (FRAC + GUARD - i);
  endfunction

  function automatic word_t sat16(input ival_t v);
    ival_t s;
    s = v >>> GUARD;
    if (s > SMAX) begin
      return word_t'(SMAX[WIDTH-1:0]);
    end else if (s < SMIN) begin
      return word_t'(SMIN[WIDTH-1:0]);
    end else begin
      return s[WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/linear_cordic_vectoring_mode_stage.sv
// One linear vectoring iteration: steer y toward zero, and
// accumulate the matching 2^-STAGE step into z.
module linear_cordic_vectoring_stage
  import cordic_pkg::*;
#(
  parameter int STAGE = 0
) (
  input  logic clk,
  input  logic reset,
  input  vec_t i_s,
  output vec_t o_s
);

  vec_t  r_s;
  ival_t w_xs;
  ival_t w_y;
  ival_t w_z;
  logic  w_dpos;

  always_comb begin
    w_xs   = (ival_t'($signed(i_s.x)) <<< GUARD) >>> STAGE;
    w_dpos = i_s.y[IW-1] != i_s.x[WIDTH-1];
    if (w_dpos) begin
      w_y = i_s.y + w_xs;
      w_z = i_s.z - inc(STAGE);
    end else begin
      w_y = i_s.y - w_xs;
      w_z = i_s.z + inc(STAGE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s <= '0;
    end else begin
      r_s.valid <= i_s.valid;
      r_s.err   <= i_s.err;
      r_s.x     <= i_s.x;
      r_s.y     <= w_y;
      r_s.z     <= w_z;
    end
  end

  assign o_s = r_s;

endmodule

// File: rtl/linear_cordic_vectoring_mode.sv
// Pipelined linear CORDIC, vectoring mode: Z_O = Z_i + Y_i / X_i.
// One sample per clock, latency of STAGES cycles, no backpressure.
module linear_cordic_vectoring_mode
  import cordic_pkg::*;
#(
  parameter int STAGES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [15:0] X_i,
  input  logic [15:0] Y_i,
  input  logic [15:0] Z_i,
  output logic        valid_o,
  output logic [15:0] X_O,
  output logic [15:0] Y_O,
  output logic [15:0] Z_O,
  output logic        err_o
);

  vec_t w_in;
  vec_t w_pipe [STAGES+1];

  logic        r_valid;
  logic        r_err;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic [15:0] r_z;

  always_comb begin
    w_in       = '0;
    w_in.valid = valid_i;
    w_in.err   = valid_i && (X_i == '0);
    w_in.x     = X_i;
    w_in.y     = ival_t'($signed(Y_i)) <<< GUARD;
    w_in.z     = ival_t'($signed(Z_i)) <<< GUARD;
  end

  assign w_pipe[0] = w_in;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    linear_cordic_vectoring_stage #(
      .STAGE(i)
    ) u_stage (
      .clk  (clk),
      .reset(reset),
      .i_s  (w_pipe[i]),
      .o_s  (w_pipe[i+1])
    );
  end

  // last stage already holds the sample; this register only
  // narrows back to Q1.14 with saturation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
    end else begin
      r_valid <= w_pipe[STAGES].valid;
      r_err   <= w_pipe[STAGES].err;
      r_x     <= w_pipe[STAGES].x;
      r_y     <= sat16(w_pipe[STAGES].y);
      r_z     <= sat16(w_pipe[STAGES].z);
    end
  end

  assign valid_o = r_valid;
  assign err_o   = r_err;
  assign X_O     = r_x;
  assign Y_O     = r_y;
  assign Z_O     = r_z;

endmodule

// File: tb/tb_linear_cordic_vectoring_mode.sv
// Self-checking bench: directed table, random stream against a
// real-valued ratio model, and reset corner sequences.
module tb_linear_cordic_vectoring_mode;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [15:0] X_i;
  logic [15:0] Y_i;
  logic [15:0] Z_i;
  logic        valid_o;
  logic [15:0] X_O;
  logic [15:0] Y_O;
  logic [15:0] Z_O;
  logic        err_o;

  linear_cordic_vectoring_mode dut (
    .clk    (clk),
    .reset  (reset),
    .valid_i(valid_i),
    .X_i    (X_i),
    .Y_i    (Y_i),
    .Z_i    (Z_i),
    .valid_o(valid_o),
    .X_O    (X_O),
    .Y_O    (Y_O),
    .Z_O    (Z_O),
    .err_o  (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] x;
    real         ez;
    bit          err;
    bit          ychk;
    int          acc;
  } exp_t;

  typedef struct {
    string name;
    int    x;
    int    y;
    int    z;
    int    ez;
    bit    err;
    bit    ychk;
  } tv_t;

  exp_t q[$];
  tv_t  tv[9];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input string detail);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Z + Y/X in Q1.14; the ratio clamps at the CORDIC reach (2-2^-15)
  function automatic real ref_z(input int x, input int y, input int z);
    real qr;
    real lim;
    real r;
    lim = 2.0 - 1.0 / 32768.0;
    if (x == 0) qr = (y >= 0) ? lim : -lim;
    else qr = real'(y) / real'(x);
    if (qr > lim) qr = lim;
    if (qr < -lim) qr = -lim;
    r = real'(z) + qr * 16384.0;
    if (r > 32767.0) r = 32767.0;
    if (r < -32768.0) r = -32768.0;
    return r;
  endfunction

  task automatic send(input int x, input int y, input int z,
                      input real ez, input bit err, input bit ychk,
                      input string name);
    exp_t e;
    valid_i = 1'b1;
    X_i = 16'(x);
    Y_i = 16'(y);
    Z_i = 16'(z);
    e.name = name;
    e.x = 16'(x);
    e.ez = ez;
    e.err = err;
    e.ychk = ychk;
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid_i = 1'b0;
      X_i = 16'($urandom);
      Y_i = 16'($urandom);
      Z_i = 16'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    check(q.size() == 0, "drain",
          $sformatf("pending=%0d required=0", q.size()));
  endtask

  initial begin : monitor
    exp_t e;
    real  d;
    forever begin
      @(posedge clk);
      #1;
      if (valid_o === 1'b1) begin
        if (q.size() == 0) begin
          check(1'b0, "spurious_valid",
                $sformatf("valid_o=1 at cycle %0d, none due", cyc));
        end else begin
          e = q.pop_front();
          check(cyc - e.acc == 16, {e.name, "_latency"},
                $sformatf("got=%0d required=16", cyc - e.acc));
          d = real'($signed(Z_O)) - e.ez;
          if (d < 0.0) d = -d;
          check(d <= 2.0, {e.name, "_z"},
                $sformatf("got=%0d required=%f+-2",
                          $signed(Z_O), e.ez));
          check(err_o === e.err, {e.name, "_err"},
                $sformatf("got=%b required=%b", err_o, e.err));
          check(X_O === e.x, {e.name, "_x"},
                $sformatf("got=%0d required=%0d",
                          $signed(X_O), $signed(e.x)));
          if (e.ychk) begin
            check($signed(Y_O) >= -2 && $signed(Y_O) <= 2,
                  {e.name, "_y"},
                  $sformatf("got=%0d required=|y|<=2", $signed(Y_O)));
          end
        end
      end
    end
  end

  initial begin
    tv[0] = '{"basic",    8192,  4096,    0,   8192, 1'b0, 1'b1};
    tv[1] = '{"neg_x",   -8192,  4096,    0,  -8192, 1'b0, 1'b0};
    tv[2] = '{"neg_y",   16384, -8192,    0,  -8192, 1'b0, 1'b0};
    tv[3] = '{"neg_xy",  -8192, -4096,    0,   8192, 1'b0, 1'b0};
    tv[4] = '{"accum",    8192,  4096, 4096,  12288, 1'b0, 1'b0};
    tv[5] = '{"edge",     8192, 16000,    0,  32000, 1'b0, 1'b0};
    tv[6] = '{"dz_pos",      0,  4096,    0,  32767, 1'b1, 1'b0};
    tv[7] = '{"ratio4",   4096, 16384,    0,  32767, 1'b0, 1'b0};
    tv[8] = '{"dz_neg",      0, -4096,    0, -32768, 1'b1, 1'b0};

    reset = 1'b1;
    valid_i = 1'b0;
    X_i = '0;
    Y_i = '0;
    Z_i = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'($urandom);
      X_i = 16'($urandom);
      Y_i = 16'($urandom);
      Z_i = 16'($urandom);
      @(negedge clk);
    end
    check(valid_o === 1'b0, "rst_valid", $sformatf("got=%b required=0", valid_o));
    check(err_o === 1'b0, "rst_err", $sformatf("got=%b required=0", err_o));
    check(X_O === 16'd0, "rst_x", $sformatf("got=%h required=0", X_O));
    check(Y_O === 16'd0, "rst_y", $sformatf("got=%h required=0", Y_O));
    check(Z_O === 16'd0, "rst_z", $sformatf("got=%h required=0", Z_O));
    reset = 1'b0;
    valid_i = 1'b0;

    send(tv[0].x, tv[0].y, tv[0].z, real'(tv[0].ez),
         tv[0].err, tv[0].ychk, tv[0].name);
    idle(20);
    drain();

    for (int i = 1; i < 9; i++) begin
      send(tv[i].x, tv[i].y, tv[i].z, real'(tv[i].ez),
           tv[i].err, tv[i].ychk, tv[i].name);
    end
    drain();

    for (int n = 0; n < 40; n++) begin
      int ax;
      int x;
      int ymax;
      int y;
      int z;
      ax = (8 + int'($urandom_range(0, 8))) * 1024;
      x = ($urandom_range(0, 1) == 1) ? -ax : ax;
      ymax = ax * 19 / 10;
      if (ymax > 32767) ymax = 32767;
      y = int'($urandom_range(0, ymax));
      if ($urandom_range(0, 1) == 1) y = -y;
      z = (n < 20) ? 0 : int'($urandom_range(0, 32767)) - 16384;
      send(x, y, z, ref_z(x, y, z), 1'b0, 1'b0, "stream");
    end
    idle(25);
    drain();

    send(8192, 4096, 0, 8192.0, 1'b0, 1'b0, "killed");
    for (int i = 0; i < 15; i++) @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    check(valid_o === 1'b0, "rst_kill",
          $sformatf("got=%b required=0", valid_o));
    idle(20);

    for (int s = 1; s <= 8; s++) begin
      int x;
      int y;
      x = 8192 + 1024 * (s % 4);
      y = 1000 * s - 3000;
      if (s == 5) begin
        reset = 1'b1;
        valid_i = 1'b1;
        X_i = 16'(x);
        Y_i = 16'(y);
        Z_i = '0;
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        valid_i = 1'b0;
        check(valid_o === 1'b0, "rst_mid",
              $sformatf("got=%b required=0", valid_o));
      end else begin
        send(x, y, 0, ref_z(x, y, 0), 1'b0, 1'b0, "post_rst");
      end
    end
    drain();
    idle(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
